rotate_ctrl: RTL

//  Sequences a piece rotation for the falling tetromino. Accepts left/right rotate requests,

---
 rtl/rotate_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/rotate_ctrl.sv
// rotate_ctrl: sequences one tetromino rotation through bounds and board-occupancy checks.
//   Clk, Reset (async, active-high)
//   rot_req_left/right, piece_lock : one-cycle requests / abort from lock logic
//   block [2:0] (CYAN=0, YELLOW=1, ...), cur_x/cur_y, cur_orient (NORMAL=0, ROT_LEFT=1, ROT2=2, ROT_RIGHT=3)
//   dp_rot_left -> rotate_blocks, dp_x/dp_y <- rotate_blocks
//   brd_rd_x/y, brd_rd_en -> board RAM, brd_occ <- board RAM (one cycle later)
//   busy, upd_valid, new_x/new_y/new_orient, rot_fail : status and result to the piece register
//   Optional wall kick (retry at x+1, then x-1) when ROT_WALL_KICK_EN is defined.
module rotate_ctrl #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int COORD_W = 5
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 rot_req_left,
  input  logic                 rot_req_right,
  input  logic                 piece_lock,
  input  logic [2:0]           block,
  input  logic [4*COORD_W-1:0] cur_x,
  input  logic [4*COORD_W-1:0] cur_y,
  input  logic [1:0]           cur_orient,
  output logic                 dp_rot_left,
  input  logic [4*COORD_W-1:0] dp_x,
  input  logic [4*COORD_W-1:0] dp_y,
  output logic [COORD_W-1:0]   brd_rd_x,
  output logic [COORD_W-1:0]   brd_rd_y,
  output logic                 brd_rd_en,
  input  logic                 brd_occ,
  output logic                 busy,
  output logic                 upd_valid,
  output logic [4*COORD_W-1:0] new_x,
  output logic [4*COORD_W-1:0] new_y,
  output logic [1:0]           new_orient,
  output logic                 rot_fail
);
  localparam logic [2:0] YELLOW = 3'd1;
  localparam logic [1:0] NORMAL = 2'd0;
  localparam logic [COORD_W:0] BW = (COORD_W+1)'(BOARD_W);
  localparam logic [COORD_W-1:0] BH = COORD_W'(BOARD_H);
  typedef enum logic [3:0] {IDLE, LATCH, CHECK0, CHECK1, CHECK2, CHECK3, DRAIN, COMMIT, REJECT} state_t;
  state_t state, nxt;
  logic dir, keep, flag, flag_n, rd_pend, accept, checking, retry;
  logic [4*COORD_W-1:0] cand_x, cand_y, sh_x;
  logic [1:0] cand_o, idx;
  logic [COORD_W:0] koff;
  logic [COORD_W:0] ext [4];
  logic [3:0] oob;
`ifdef ROT_WALL_KICK_EN
  logic [1:0] kick;
  // kick 0: no shift, 1: x+1, 2: x-1 (all-ones offset wraps column 0 out of bounds)
  assign koff = kick == 2'd1 ? (COORD_W+1)'(1) : kick == 2'd2 ? '1 : '0;
  assign retry = kick != 2'd2;
`else
  assign koff = '0;
  assign retry = 1'b0;
`endif
  // one extra bit so x+1 overflow and x-1 underflow both land at or above BOARD_W
  for (genvar i = 0; i < 4; i++) begin : g_cell
    assign ext[i] = {1'b0, cand_x[i*COORD_W +: COORD_W]} + koff;
    assign sh_x[i*COORD_W +: COORD_W] = ext[i][COORD_W-1:0];
    assign oob[i] = ext[i] >= BW || cand_y[i*COORD_W +: COORD_W] >= BH;
  end
  assign checking = state inside {CHECK0, CHECK1, CHECK2, CHECK3};
  assign idx = 2'(state - CHECK0);
  // busy covers the result pulse cycle so a request there is dropped
  assign busy = state != IDLE || upd_valid || rot_fail;
  assign accept = !busy && (rot_req_left ^ rot_req_right) && !piece_lock;
  assign brd_rd_en = checking && !oob[idx] && !piece_lock;
  assign brd_rd_x = brd_rd_en ? sh_x[idx*COORD_W +: COORD_W] : '0;
  assign brd_rd_y = brd_rd_en ? cand_y[idx*COORD_W +: COORD_W] : '0;
  assign flag_n = flag || (rd_pend && brd_occ) || (checking && oob[idx]);
  assign dp_rot_left = dir;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = accept ? (block == YELLOW ? COMMIT : LATCH) : IDLE;
      LATCH, CHECK0, CHECK1, CHECK2, CHECK3: nxt = state_t'(state + 4'd1);
      DRAIN: nxt = !flag_n ? COMMIT : retry ? CHECK0 : REJECT;
      default: nxt = IDLE;
    endcase
    if (piece_lock && state != IDLE) nxt = IDLE;
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      dir <= 1'b0;
      keep <= 1'b0;
      flag <= 1'b0;
      rd_pend <= 1'b0;
      cand_x <= '0;
      cand_y <= '0;
      cand_o <= NORMAL;
      upd_valid <= 1'b0;
      rot_fail <= 1'b0;
      new_x <= '0;
      new_y <= '0;
      new_orient <= NORMAL;
`ifdef ROT_WALL_KICK_EN
      kick <= 2'd0;
`endif
    end else begin
      state <= nxt;
      rd_pend <= brd_rd_en;
      upd_valid <= state == COMMIT && !piece_lock;
      rot_fail <= state == REJECT && !piece_lock;
      flag <= checking && !piece_lock ? flag_n : 1'b0;
      if (accept) begin
        dir <= rot_req_left;
        keep <= block == YELLOW;
        cand_x <= cur_x;
        cand_y <= cur_y;
        cand_o <= cur_orient;
      end
      if (state == LATCH) begin
        cand_x <= dp_x;
        cand_y <= dp_y;
        cand_o <= cur_orient;
      end
`ifdef ROT_WALL_KICK_EN
      kick <= accept ? 2'd0 : state == DRAIN && flag_n && retry ? kick + 2'd1 : kick;
`endif
      if (state == COMMIT && !piece_lock) begin
        new_x <= sh_x;
        new_y <= cand_y;
        new_orient <= keep ? cand_o : dir ? cand_o + 2'd1 : cand_o - 2'd1;
      end
    end
endmodule
